// File: rtl/seven_seg_scanner_pkg.sv
// Shared seven-segment constants (active-low gfedcba) and a digit-select helper.
// The score counter draws on the same pattern set.
package seven_seg_scanner_pkg;

   localparam logic [6:0] ZERO  = 7'b1000000;
   localparam logic [6:0] ONE   = 7'b1111001;
   localparam logic [6:0] TWO   = 7'b0100100;
   localparam logic [6:0] THREE = 7'b0110000;
   localparam logic [6:0] FOUR  = 7'b0011001;
   localparam logic [6:0] FIVE  = 7'b0010010;
   localparam logic [6:0] SIX   = 7'b0000010;
   localparam logic [6:0] SEVEN = 7'b1111000;
   localparam logic [6:0] EIGHT = 7'b0000000;
   localparam logic [6:0] NINE  = 7'b0010000;
   localparam logic [6:0] BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF = 4'b1111;

   function automatic logic [6:0] digit_of(input logic [27:0] word, input logic [1:0] sel);
      case (sel)
         2'd0:    return word[6:0];
         2'd1:    return word[13:7];
         2'd2:    return word[20:14];
         default: return word[27:21];
      endcase
   endfunction

endpackage

// File: rtl/seven_seg_scanner_timebase.sv
// Digit dwell counter and digit index for a four-position scan, plus a
// frame-end strobe on the last tick of the last digit.
module scan_timebase #(
   parameter int DIGIT_PERIOD = 100000
) (
   input  logic                                                clk,
   input  logic                                                rst,
   output logic [((DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1)-1:0] tick,
   output logic [1:0]                                          idx,
   output logic                                                frame_end
);

   localparam int TICK_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_PERIOD - 1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         tick <= '0;
         idx  <= 2'd0;
      end else if (tick == TICK_LAST) begin
         tick <= '0;
         idx  <= idx + 2'd1;
      end else begin
         tick <= tick + TICK_W'(1);
      end
   end

   assign frame_end = (idx == 2'd3) && (tick == TICK_LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit seven-segment scanner with per-frame snapshots, an all-anodes-off
// guard at the start of each dwell, leading-zero blanking and whole-display blink.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int DIGIT_PERIOD = 100000,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [27:0] display_all,
   input  logic [3:0]  dp_in,
   input  logic        lz_blank,
   input  logic        blink_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int TICK_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

   logic [TICK_W-1:0] tick;
   logic [1:0]        idx;
   logic              frame_end;

   scan_timebase #(.DIGIT_PERIOD(DIGIT_PERIOD)) u_timebase (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .idx       (idx),
      .frame_end (frame_end)
   );

   logic [27:0]     snap;
   logic [3:0]      snap_dp;
   logic [3:0]      mask;
   logic            loaded;
   logic [FR_W-1:0] frame_cnt;
   logic            phase;
   logic [3:0]      next_mask;
   logic            dark;

   // Blanking chains downward from digit3; the rightmost digit always shows.
   always_comb begin
      next_mask    = 4'b0000;
      next_mask[3] = lz_blank && (display_all[27:21] == ZERO);
      next_mask[2] = next_mask[3] && (display_all[20:14] == ZERO);
      next_mask[1] = next_mask[2] && (display_all[13:7] == ZERO);
   end

   // No anode is driven until the first real snapshot has been captured.
   always_comb begin
      dark = (32'(tick) < 32'(BLANK_CYCLES)) || (blink_en && !phase) || mask[idx] || !loaded;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         snap       <= {4{BLANK}};
         snap_dp    <= 4'b0000;
         mask       <= 4'b0000;
         loaded     <= 1'b0;
         frame_cnt  <= '0;
         phase      <= 1'b1;
         an         <= AN_OFF;
         seg        <= BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            snap    <= display_all;
            snap_dp <= dp_in;
            mask    <= next_mask;
            loaded  <= 1'b1;
         end
         if (!blink_en) begin
            frame_cnt <= '0;
            phase     <= 1'b1;
         end else if (frame_end) begin
            if (frame_cnt == FR_LAST) begin
               frame_cnt <= '0;
               phase     <= ~phase;
            end else begin
               frame_cnt <= frame_cnt + FR_W'(1);
            end
         end
         if (dark) begin
            an  <= AN_OFF;
            seg <= BLANK;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= digit_of(snap, idx);
            dp  <= ~snap_dp[idx];
         end
      end
   end

endmodule
